// File: rtl/vga_scan_pkg.sv
// Shared types and constants for the VGA scan generator.
// The colour-bar table is only referenced when VGA_TESTPAT_EN is defined.
package vga_scan_pkg;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'd0,
    SCALE_2X   = 2'd1,
    SCALE_4X   = 2'd2,
    SCALE_RSVD = 2'd3
  } scale_mode_e;

  localparam int unsigned NUM_BARS = 8;

  // RGB444 bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [11:0] COLOUR_BARS [NUM_BARS] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic logic [1:0] mode_shift(input scale_mode_e mode);
    case (mode)
      SCALE_2X: return 2'd1;
      SCALE_4X: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset and synchronous flush,
// both loading the RST_VAL pattern into every stage.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= RST_VAL;
      end
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= RST_VAL;
      end
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA timing and framebuffer readout with 1x/2x/4x pixel replication.
// Define VGA_TESTPAT_EN to add the i_test_pat colour-bar override.
module vga_scan_gen
  import vga_scan_pkg::*;
#(
  parameter int unsigned H_REZ        = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_REZ        = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter logic        HSYNC_ACTIVE = 1'b0,
  parameter logic        VSYNC_ACTIVE = 1'b0,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned PIX_W        = 12
) (
  input  logic              i_clk25,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [1:0]        i_scale_mode,
`ifdef VGA_TESTPAT_EN
  input  logic              i_test_pat,
`endif
  output logic [ADDR_W-1:0] o_frame_addr,
  input  logic [PIX_W-1:0]  i_frame_pixel,
  output logic [3:0]        o_vga_red,
  output logic [3:0]        o_vga_green,
  output logic [3:0]        o_vga_blue,
  output logic              o_vga_hsync,
  output logic              o_vga_vsync,
  output logic              o_frame_start,
  output logic              o_active
);

  localparam int unsigned HMAX = H_REZ + H_FP + H_SYNC + H_BP;
  localparam int unsigned VMAX = V_REZ + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW   = $clog2(HMAX);
  localparam int unsigned VW   = $clog2(VMAX);
  localparam int unsigned DLY  = 2 + RD_LAT;
  localparam logic [2:0]  SYNC_IDLE = {~HSYNC_ACTIVE, ~VSYNC_ACTIVE, 1'b0};

  logic              r_alive;
  logic [HW-1:0]     r_hcnt;
  logic [VW-1:0]     r_vcnt;
  logic [1:0]        r_shift;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  r_pix;

  logic              w_run;
  logic              w_clr;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_frame_start;
  logic              w_active;
  logic              w_hsync;
  logic              w_vsync;
  logic              w_row_step;
  logic [1:0]        w_shift;
  logic [VW-1:0]     w_vnext;
  logic [2:0]        w_dly_q;
  logic [PIX_W-1:0]  w_pix_src;

  // r_alive holds the scan off for the first edge after reset release so
  // frame_start is never lost to a counter that has already advanced.
  always_comb begin
    w_run         = i_en & r_alive;
    w_clr         = ~w_run;
    w_h_last      = (r_hcnt == HW'(HMAX - 1));
    w_v_last      = (r_vcnt == VW'(VMAX - 1));
    w_frame_start = w_run && (r_hcnt == '0) && (r_vcnt == '0);
    w_active      = w_run && (r_hcnt < HW'(H_REZ)) && (r_vcnt < VW'(V_REZ));
    w_hsync       = (w_run && (r_hcnt >= HW'(H_REZ + H_FP))
                     && (r_hcnt < HW'(H_REZ + H_FP + H_SYNC))) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
    w_vsync       = (w_run && (r_vcnt >= VW'(V_REZ + V_FP))
                     && (r_vcnt < VW'(V_REZ + V_FP + V_SYNC))) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    // The first line of a frame must already use the newly latched mode.
    w_shift       = w_frame_start ? mode_shift(scale_mode_e'(i_scale_mode)) : r_shift;
    w_vnext       = r_vcnt + 1'b1;
    case (r_shift)
      2'd1:    w_row_step = ~w_vnext[0];
      2'd2:    w_row_step = (w_vnext[1:0] == 2'b00);
      default: w_row_step = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alive    <= 1'b0;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_shift    <= 2'd0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else begin
      r_alive <= 1'b1;
      if (!w_run) begin
        r_hcnt     <= '0;
        r_vcnt     <= '0;
        r_shift    <= 2'd0;
        r_row_base <= '0;
        r_addr     <= '0;
      end else begin
        if (w_h_last) begin
          r_hcnt <= '0;
          r_vcnt <= w_v_last ? '0 : w_vnext;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end

        if (w_frame_start) begin
          r_shift <= w_shift;
        end

        // Row base steps once per replicated source row, so no multiplier is needed.
        if (w_h_last && w_v_last) begin
          r_row_base <= '0;
        end else if ((r_hcnt == HW'(H_REZ - 1)) && (r_vcnt < VW'(V_REZ)) && w_row_step) begin
          r_row_base <= r_row_base + ADDR_W'(H_REZ >> r_shift);
        end

        r_addr <= w_active ? (r_row_base + ADDR_W'(r_hcnt >> w_shift)) : '0;
      end
    end
  end

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .i_clk   (i_clk25),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_d     ({w_hsync, w_vsync, w_active}),
    .o_q     (w_dly_q)
  );

`ifdef VGA_TESTPAT_EN
  localparam int unsigned BAR_W = H_REZ / NUM_BARS;

  logic [2:0] w_bar_idx;
  logic [2:0] w_bar_q;

  always_comb begin
    w_bar_idx = w_active ? 3'(32'(r_hcnt) / BAR_W) : 3'd0;
  end

  // Bar index is delayed to the cycle in which the memory pixel would arrive.
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (RD_LAT + 1),
    .RST_VAL (3'd0)
  ) u_bar_dly (
    .i_clk   (i_clk25),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_d     (w_bar_idx),
    .o_q     (w_bar_q)
  );

  always_comb begin
    w_pix_src = i_test_pat ? PIX_W'(COLOUR_BARS[w_bar_q]) : i_frame_pixel;
  end
`else
  always_comb begin
    w_pix_src = i_frame_pixel;
  end
`endif

  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix <= '0;
    end else if (!w_run) begin
      r_pix <= '0;
    end else begin
      r_pix <= w_pix_src;
    end
  end

  always_comb begin
    o_frame_addr  = r_addr;
    o_frame_start = w_frame_start;
    o_vga_hsync   = w_dly_q[2];
    o_vga_vsync   = w_dly_q[1];
    o_active      = w_dly_q[0];
    o_vga_red     = w_dly_q[0] ? r_pix[11:8] : 4'h0;
    o_vga_green   = w_dly_q[0] ? r_pix[7:4]  : 4'h0;
    o_vga_blue    = w_dly_q[0] ? r_pix[3:0]  : 4'h0;
  end

endmodule
